// File: rtl/r4_pkg.sv
// Shared definitions for the radix-4 frame sequencer: sample width, the
// per-output butterfly control codes, frame record and read FSM states.
package r4_pkg;

  localparam int unsigned R4_W = 4;

  // {c1,c2,c3} for output index k
  localparam logic [2:0] R4_CODE_K0 = 3'b011;
  localparam logic [2:0] R4_CODE_K1 = 3'b101;
  localparam logic [2:0] R4_CODE_K2 = 3'b000;
  localparam logic [2:0] R4_CODE_K3 = 3'b110;

  typedef struct packed {
    logic [R4_W-1:0] re;
    logic [R4_W-1:0] im;
  } r4_sample_t;

  typedef r4_sample_t [3:0] r4_frame_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  function automatic logic [2:0] r4_code(input logic [1:0] k);
    logic [2:0] code;
    case (k)
      2'd0:    code = R4_CODE_K0;
      2'd1:    code = R4_CODE_K1;
      2'd2:    code = R4_CODE_K2;
      default: code = R4_CODE_K3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/r4_frame_sequencer_bank.sv
// Ping-pong pair of 4-sample banks: serial write side with full flags, and a
// read-bank view that the sequencer frees with a one-cycle clear strobe.
module r4_pingpong_bank
  import r4_pkg::*;
#(
  parameter int unsigned W = R4_W
) (
  input  logic           CLOCK,
  input  logic           RESET,
  input  logic           i_valid,
  input  logic [W-1:0]   i_re,
  input  logic [W-1:0]   i_im,
  input  logic           i_clear,
  output logic           o_ready,
  output logic           o_rd_full,
  output logic [4*W-1:0] o_rd_re,
  output logic [4*W-1:0] o_rd_im
);

  logic [W-1:0] r_re [2][4];
  logic [W-1:0] r_im [2][4];
  logic [1:0]   r_full;
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic [1:0]   r_wr_cnt;
  logic         w_wr_en;

  assign o_ready   = ~r_full[r_wr_bank];
  assign o_rd_full = r_full[r_rd_bank];
  assign w_wr_en   = i_valid & o_ready;

  // A bank being written is never full, so set and clear never collide.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_cnt <= r_wr_cnt + 2'd1;
        if (r_wr_cnt == 2'd3) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
        end
      end
      if (i_clear) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_wr_en) begin
      r_re[r_wr_bank][r_wr_cnt] <= i_re;
      r_im[r_wr_bank][r_wr_cnt] <= i_im;
    end
  end

  always_comb begin
    o_rd_re = '0;
    o_rd_im = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      o_rd_re[i*W +: W] = r_re[r_rd_bank][i];
      o_rd_im[i*W +: W] = r_im[r_rd_bank][i];
    end
  end

endmodule

// File: rtl/r4_frame_sequencer.sv
// Radix-4 butterfly feeder: launches 4-sample frames from the ping-pong bank
// and sequences control codes and the valid/index strobe per output index.
module r4_frame_sequencer
  import r4_pkg::*;
#(
  parameter int unsigned W = R4_W
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic [W-1:0] xr0,
  output logic [W-1:0] xi0,
  output logic [W-1:0] xr1,
  output logic [W-1:0] xi1,
  output logic [W-1:0] xr2,
  output logic [W-1:0] xi2,
  output logic [W-1:0] xr3,
  output logic [W-1:0] xi3,
  output logic         c1,
  output logic         c2,
  output logic         c3,
  output logic         bf_valid,
  output logic [1:0]   bf_index,
  output logic         frame_start
);

  rd_state_t    r_state;
  logic [1:0]   r_rd_cnt;
  logic [W-1:0] r_xr [4];
  logic [W-1:0] r_xi [4];
  logic [2:0]   r_code;
  logic         r_code_vld;
  logic [1:0]   r_code_idx;
  logic         r_bf_valid;
  logic [1:0]   r_bf_index;
  logic         r_frame_start;

  logic           w_rd_full;
  logic           w_launch;
  logic [4*W-1:0] w_rd_re;
  logic [4*W-1:0] w_rd_im;

  r4_pingpong_bank #(.W(W)) u_bank (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .i_valid   (in_valid),
    .i_re      (in_re),
    .i_im      (in_im),
    .i_clear   (w_launch),
    .o_ready   (in_ready),
    .o_rd_full (w_rd_full),
    .o_rd_re   (w_rd_re),
    .o_rd_im   (w_rd_im)
  );

  assign w_launch = w_rd_full & ((r_state == RD_IDLE) | (r_rd_cnt == 2'd3));

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state  <= RD_IDLE;
      r_rd_cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_xr[i] <= '0;
        r_xi[i] <= '0;
      end
    end else if (w_launch) begin
      r_state  <= RD_RUN;
      r_rd_cnt <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_xr[i] <= w_rd_re[i*W +: W];
        r_xi[i] <= w_rd_im[i*W +: W];
      end
    end else if (r_state == RD_RUN) begin
      r_rd_cnt <= r_rd_cnt + 2'd1;
      if (r_rd_cnt == 2'd3) r_state <= RD_IDLE;
    end
  end

  // Code stage trails the read counter by one edge (butterfly input register),
  // valid/index trails the code by one more (butterfly output register).
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_code        <= '0;
      r_code_vld    <= 1'b0;
      r_code_idx    <= '0;
      r_bf_valid    <= 1'b0;
      r_bf_index    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_launch;
      r_code_vld    <= (r_state == RD_RUN);
      r_code_idx    <= r_rd_cnt;
      r_code        <= (r_state == RD_RUN) ? r4_code(r_rd_cnt) : 3'b000;
      r_bf_valid    <= r_code_vld;
      r_bf_index    <= r_code_vld ? r_code_idx : 2'd0;
    end
  end

  assign xr0 = r_xr[0];
  assign xi0 = r_xi[0];
  assign xr1 = r_xr[1];
  assign xi1 = r_xi[1];
  assign xr2 = r_xr[2];
  assign xi2 = r_xi[2];
  assign xr3 = r_xr[3];
  assign xi3 = r_xi[3];

  assign c1          = r_code[2];
  assign c2          = r_code[1];
  assign c3          = r_code[0];
  assign bf_valid    = r_bf_valid;
  assign bf_index    = r_bf_index;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_r4_frame_sequencer.sv
// Scoreboard bench for r4_frame_sequencer: a frame-level reference model
// queues per-cycle expectations; a monitor compares them after each edge.
module tb_r4_frame_sequencer;
  import r4_pkg::*;

  localparam int unsigned W = R4_W;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic [W-1:0] xr0, xi0, xr1, xi1, xr2, xi2, xr3, xi3;
  logic         c1, c2, c3;
  logic         bf_valid;
  logic [1:0]   bf_index;
  logic         frame_start;

  r4_frame_sequencer #(.W(W)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re       (in_re),
    .in_im       (in_im),
    .xr0         (xr0),
    .xi0         (xi0),
    .xr1         (xr1),
    .xi1         (xi1),
    .xr2         (xr2),
    .xi2         (xi2),
    .xr3         (xr3),
    .xi3         (xi3),
    .c1          (c1),
    .c2          (c2),
    .c3          (c3),
    .bf_valid    (bf_valid),
    .bf_index    (bf_index),
    .frame_start (frame_start)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic      in_ready;
    logic      fs;
    logic [2:0] code;
    logic      bfv;
    logic [1:0] bfi;
    r4_frame_t x;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model: frames waiting to launch, partially built frame,
  // last launched frame, and the edge numbers of the most recent launches.
  logic [2:0]  ctab [4] = '{3'b011, 3'b101, 3'b000, 3'b110};
  r4_frame_t   pend_q[$];
  r4_frame_t   cur;
  int          pc = 0;
  r4_frame_t   m_x = '0;
  int          launches[$];
  int          edge_n = 0;
  int unsigned n_acc = 0;

  task automatic model_step();
    exp_t e;
    logic acc;
    logic launch;
    int   k;
    edge_n++;
    e = '0;
    if (!RESET) begin
      pend_q.delete();
      launches.delete();
      pc  = 0;
      m_x = '0;
      e.in_ready = 1'b1;
      exp_q.push_back(e);
      return;
    end
    acc    = in_valid && (pend_q.size() < 2);
    launch = (pend_q.size() > 0) && (launches.size() == 0 || edge_n - launches[$] >= 4);
    if (launch) begin
      m_x = pend_q.pop_front();
      launches.push_back(edge_n);
      if (launches.size() > 2) void'(launches.pop_front());
    end
    if (acc) begin
      n_acc++;
      cur[pc].re = in_re;
      cur[pc].im = in_im;
      pc++;
      if (pc == 4) begin
        pend_q.push_back(cur);
        pc = 0;
      end
    end
    e.in_ready = (pend_q.size() < 2);
    e.fs       = launch;
    e.x        = m_x;
    foreach (launches[i]) begin
      k = edge_n - 1 - launches[i];
      if (k >= 0 && k <= 3) e.code = ctab[k];
      k = edge_n - 2 - launches[i];
      if (k >= 0 && k <= 3) begin
        e.bfv = 1'b1;
        e.bfi = 2'(k);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic v, input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic rstn);
    @(negedge CLOCK);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    RESET    = rstn;
    model_step();
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im);
    tick(1'b1, re, im, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b1);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  exp_t      mon_e;
  r4_frame_t mon_x;

  initial begin
    forever begin
      @(posedge CLOCK);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_x[0].re = xr0; mon_x[0].im = xi0;
        mon_x[1].re = xr1; mon_x[1].im = xi1;
        mon_x[2].re = xr2; mon_x[2].im = xi2;
        mon_x[3].re = xr3; mon_x[3].im = xi3;
        chk("in_ready", 64'(in_ready), 64'(mon_e.in_ready));
        chk("frame_start", 64'(frame_start), 64'(mon_e.fs));
        chk("x_words", 64'(mon_x), 64'(mon_e.x));
        chk("code", 64'({c1, c2, c3}), 64'(mon_e.code));
        chk("bf_valid", 64'(bf_valid), 64'(mon_e.bfv));
        if (mon_e.bfv) chk("bf_index", 64'(bf_index), 64'(mon_e.bfi));
      end
    end
  end

  initial begin
    int cyc;
    tick(1'b0, '0, '0, 1'b0);
    tick(1'b0, '0, '0, 1'b0);
    idle(1);
    send(4'd1, 4'd2);
    send(4'd3, 4'd4);
    send(4'd5, 4'd6);
    send(4'd7, 4'd8);
    idle(8);

    for (int i = 0; i < 16; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(8);

    for (int i = 0; i < 12; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(8);

    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      idle(2);
    end
    idle(8);

    // Reset after the k=1 result with a partially filled second bank.
    for (int i = 0; i < 6; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(2);
    tick(1'b0, '0, '0, 1'b0);
    idle(6);
    for (int i = 0; i < 4; i++) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    idle(8);

    n_acc = 0;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 5000) begin
      tick($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      cyc++;
    end
    chk("random_accepts", 64'(n_acc), 64'd1000);
    idle(10);

    @(posedge CLOCK);
    #2;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
